// File: rtl/wb_mem_arbiter_pkg.sv
// wb_arb_pkg: shared state encoding, arbitration modes and width helper
package wb_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_ERR = 2'd2} state_e;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if: N-master / single-slave Wishbone bundle around the arbiter
interface wb_mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [NUM_MASTERS-1:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, m_stall_o;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [DATA_WIDTH-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  modport arb (
    input m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
    input m_dat_o, m_ack_o, m_err_o, m_stall_o
  );
  modport slave (
    input s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_mem_arbiter_picker.sv
// wb_arb_picker: combinational fixed-priority / round-robin winner selection
module wb_arb_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         mode_i,
  output logic [N-1:0] win_o,
  output logic [W-1:0] idx_o
);
  // scan from the far end so the first requester at/after the start point is written last
  always_comb begin
    int j;
    j = 0;
    win_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ((mode_i ? int'(ptr_i) : 0) + k) % N;
      if (req_i[j]) begin
        win_o = '0;
        win_o[j] = 1'b1;
        idx_o = W'(j);
      end
    end
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: N-master to one-slave Wishbone arbiter with bus lock and timeout
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_mem_arbiter_if.arb          bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int CW = idx_w(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, win;
  logic [IW-1:0] gidx_q, gidx_d, rr_q, rr_d, widx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gnt, stb_wait, tmo_hit;
  wb_arb_picker #(.N(NUM_MASTERS), .W(IW)) u_picker (
    .req_i(bus.m_cyc_i),
    .ptr_i(rr_q),
    .mode_i(ARB_MODE == ARB_RR),
    .win_o(win),
    .idx_o(widx)
  );
  assign gnt = state_q == ST_GRANT;
  assign stb_wait = bus.s_stb_o & ~bus.s_ack_i;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) == TIMEOUT_CYCLES - 1);
  assign bus.s_cyc_o = gnt & bus.m_cyc_i[gidx_q];
  assign bus.s_stb_o = gnt & bus.m_stb_i[gidx_q];
  assign bus.s_we_o = gnt & bus.m_we_i[gidx_q];
  assign bus.s_adr_o = gnt ? bus.m_adr_i[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_dat_o = gnt ? bus.m_dat_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = (gnt && bus.s_ack_i) ? grant_q : '0;
  assign bus.m_err_o = (state_q == ST_ERR) ? grant_q : '0;
  assign bus.m_stall_o = bus.m_cyc_i & ~grant_q;
  assign grant_o = grant_q;
  assign busy_o = gnt;
  // arbitrate in IDLE, hold the grant while cyc stays up, count unacked strobes
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    rr_d = rr_q;
    cnt_d = '0;
    if (state_q == ST_IDLE) begin
      if (|bus.m_cyc_i) begin
        state_d = ST_GRANT;
        grant_d = win;
        gidx_d = widx;
        rr_d = (widx == IW'(NUM_MASTERS - 1)) ? '0 : widx + 1'b1;
      end
    end else if (state_q == ST_GRANT) begin
      if (!bus.m_cyc_i[gidx_q]) begin
        state_d = ST_IDLE;
        grant_d = '0;
      end else if (stb_wait && tmo_hit) begin
        state_d = ST_ERR;
      end else if (stb_wait) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      grant_d = '0;
    end
  end
  // state and grant registers; reset drops the slave cycle without waiting for a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- N-master to single-slave Wishbone arbiter placed in front of each osiris_i memory (instruction and data).
- Replaces ad-hoc select_mem muxing: core fetch, core load/store and uart_wbs_bridge each get a master port.
- Losers are stalled instead of silently colliding.
- Generalised in master count, widths and arbitration mode; adds bus locking, per-master stall and a bus-error timeout.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8); master 0 has highest fixed priority.
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 10, word address width passed to memory.
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin.
- TIMEOUT_CYCLES, 255, cycles with stb high and no ack before error; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  ack, only to granted master
- m_err_o  out  NUM_MASTERS  one-cycle timeout error pulse
- m_stall_o  out  NUM_MASTERS  request pending but not granted
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  NUM_MASTERS  one-hot current grant
- busy_o  out  1  state == GRANT

Behaviour:
- Reset (rst low, async): state IDLE, grant_o = 0, rr_ptr = 0, timeout counter = 0, m_err_o = 0.
- Idle outputs: all slave outputs 0; m_ack_o = 0; m_stall_o = m_cyc_i.
- FSM states are IDLE, GRANT and ERR.
- IDLE: if any m_cyc_i is high, pick a winner and register grant_o; enter GRANT next edge. Arbitration latency is 1 cycle.
- Fixed priority (ARB_MODE 0): lowest index among requesters wins.
- Round-robin (ARB_MODE 1): first requester at or after rr_ptr wins, searching modulo NUM_MASTERS. On grant, rr_ptr <= winner+1 (wraps to 0 past NUM_MASTERS-1).
- GRANT routing (combinational, zero latency):
  - s_cyc/stb/we/adr/dat take the granted master's signals.
  - m_ack_o[g] = s_ack_i.
  - m_dat_o = s_dat_i always.
- Bus lock: grant is held while m_cyc_i[g] is high, across multiple stb/ack beats. No preemption, even by a higher-priority master.
- Release: when m_cyc_i[g] drops, return to IDLE next edge and clear grant_o. There is one dead cycle before the next grant.
- Stall: m_stall_o[i] = m_cyc_i[i] & ~grant_o[i], in every state.
- Timeout:
  - Counter increments each GRANT cycle with s_stb_o high and s_ack_i low.
  - Counter clears on ack, on stb low, or on leaving GRANT.
  - When the counter reaches TIMEOUT_CYCLES, go to ERR.
- ERR (1 cycle): slave outputs forced 0, m_err_o[g] = 1, grant_o retained. Then go to IDLE with grant cleared.
- Simultaneous s_ack_i on the timeout cycle: the ack wins; no error is raised.
- Master drops cyc in ERR: no effect; ERR still exits to IDLE.
- Granted master withdraws stb but holds cyc: the grant is kept; slave stb = 0.
- Reset asserted mid-transfer: immediate return to reset values; the slave sees cyc drop asynchronously.

Decomposition:
- Package wb_arb_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_ERR = 2'd2;
  - ARB_FIXED = 0, ARB_RR = 1;
  - a clog2-based index-width function.
- Sub-module wb_arb_picker (combinational): inputs request vector, rr_ptr and mode; outputs one-hot winner and winner index. It is reused by future multi-slave interconnects.

Test Plan:
- Single master: master 1 write adr 0x010 dat 0xDEADBEEF, mem acks in 1 cycle → grant_o = 2'b10 one cycle after cyc; m_ack_o = 2'b10; memory word 0x010 = 0xDEADBEEF.
- Contention, fixed mode: masters 0 and 1 raise cyc in the same cycle → grant_o = 01, m_stall_o = 10 until master 0 drops cyc; master 1 granted 2 cycles later (1 release cycle + 1 arbitration cycle).
- Round-robin, NUM_MASTERS = 3, all requesting continuously with 1-beat cycles → grant order 0,1,2,0,1,2; rr_ptr wraps 2→0.
- Bus lock: master 1 holds cyc for 4 beats while master 0 requests → master 0 stalled for all 4 acks; no preemption.
- Timeout, TIMEOUT_CYCLES = 4, slave never acks → m_err_o[g] pulses exactly 1 cycle after the 4th unacked stb cycle; slave cyc = 0 in ERR; grant cleared next cycle. Variant with ack on cycle 4 → no error.
- Reset mid-transfer: assert rst low while in GRANT → grant_o, s_cyc_o and busy_o go to 0 without a clock edge; the first request after release is granted with rr_ptr = 0.
